joypad_device: RTL and testbench
================================

JOYPAD_DEVICE -- requirements
Module: joypad_device

Interface
REQ-001 SHALL provide: clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-002 SHALL provide: res  input  1  reset; synchronous, active-high.
REQ-003 SHALL provide: latch  input  1  console latch line; asynchronous to clk, active-high.
REQ-004 SHALL provide: clkin  input  1  console serial clock line; asynchronous to clk, idles high.
REQ-005 SHALL provide: button_data  input  12  active-high pressed flags; bits 0-11 are up, down, left, right, A, B, X, Y, L, R, select, start.
REQ-006 SHALL provide: data  output  1  serial data to console; registered, active-low (0 = pressed).
REQ-007 SHALL provide: frame_done  output  1  one-cycle pulse when the 16th serial bit has been consumed.

Function
REQ-008 SHALL pass latch and clkin each through a two-flop synchronizer, then one edge-detect register; edge-to-action latency is 3 clk cycles.
REQ-009 SHALL map wire bit order 0-15 as B, Y, select, start, up, down, left, right, A, X, L, R, then four ID bits fixed at 0 (released, data high).
REQ-010 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-011 IDLE: data = 1; synchronized latch high -> LOAD.
REQ-012 LOAD: reload the 16-bit shift register from button_data every cycle; data = ~bit0 (B); synchronized latch falling edge -> SHIFT with bit index 0.
REQ-013 SHIFT: on each synchronized clkin rising edge, advance the index by 1 and drive data = ~bit[index]; after the edge that consumes bit 15 -> DONE.
REQ-014 DONE: data = 0 (standard controller behaviour after 16 bits); further clkin edges are ignored; frame_done pulses for exactly one cycle on DONE entry.
REQ-015 A synchronized latch high in any state SHALL force LOAD on the next cycle and abandon any partial frame without asserting frame_done.
REQ-016 A latch rising edge and a clkin rising edge detected in the same cycle SHALL be resolved in favour of latch.
REQ-017 button_data changes during SHIFT or DONE SHALL NOT affect the frame in progress; sampling occurs only in LOAD.
REQ-018 The bit index SHALL be 4 bits wide and SHALL NOT wrap; reaching 15 ends the frame.
REQ-019 clkin edges in IDLE or LOAD SHALL be ignored.

Reset
REQ-020 With res high at a clk edge: state = IDLE, data = 1, frame_done = 0, bit index = 0, shift register = 16'hFFFF-equivalent released, synchronizers = latch 0 and clkin 1.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after res deasserts, a new frame requires a fresh latch.

Configuration
REQ-022 Macro JOYPAD_DEVICE_TIMEOUT_EN: when defined, an 11-bit counter runs in SHIFT and clears on each accepted clkin edge; at count 1371 the state SHALL return to IDLE with data = 1 and no frame_done pulse.
REQ-023 Without JOYPAD_DEVICE_TIMEOUT_EN, SHIFT SHALL persist indefinitely until 16 edges, latch, or reset, and no counter is instantiated.

Verification
REQ-024 Reset, then press B only (button_data = 12'h020), pulse latch, apply 16 clkin pulses -> data 0 for bit 0 and 1 for bits 1-15, then 0 in DONE, with a single frame_done pulse.
REQ-025 button_data = 12'hFFF, full frame -> bits 0-11 are 0 and bits 12-15 are 1; a reader decoding 16 bits as inverted data recovers 12'hFFF.
REQ-026 Latch reasserted after 5 clkin pulses -> return to LOAD, data = ~B, no frame_done; the next full frame is correct.
REQ-027 Change button_data from 12'h001 to 12'h800 after the latch falls -> the frame carries up pressed and start released.
REQ-028 Latch rise coincident with a clkin rise -> LOAD taken and no index advance.
REQ-029 With JOYPAD_DEVICE_TIMEOUT_EN: latch, 3 clkin pulses, then 1372 idle cycles -> IDLE, data = 1, no frame_done; without the macro -> still in SHIFT at index 3.

Source files
------------

// File: rtl/joypad_device_if.sv
// Console-side joypad bus: latch and serial clock from the console, serial data back to it.
interface joypad_device_if;
    logic latch;
    logic clkin;
    logic data;

    modport master (
        output latch,
        output clkin,
        input  data
    );

    modport slave (
        input  latch,
        input  clkin,
        output data
    );
endinterface

// File: rtl/joypad_device.sv
// Serial joypad controller device: latches 12 buttons plus 4 ID bits and shifts them out
// active-low on console clock edges. Optional shift timeout via JOYPAD_DEVICE_TIMEOUT_EN.
module joypad_device (
    input  logic                   clk,
    input  logic                   res,
    joypad_device_if.slave         bus,
    input  logic [11:0]            button_data,
    output logic                   frame_done
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] shreg_q, shreg_d;
    logic        data_q, data_d;
    logic        frame_done_q, frame_done_d;

    logic        latch_s1_q, latch_s2_q, latch_p_q;
    logic        clkin_s1_q, clkin_s2_q, clkin_p_q;
    logic        latch_sync, latch_fall, clk_rise;
    logic [15:0] load_word;

`ifdef JOYPAD_DEVICE_TIMEOUT_EN
    logic [10:0] cnt_q, cnt_d;
`endif

    assign latch_sync = latch_s2_q;
    assign latch_fall = ~latch_s2_q & latch_p_q;
    assign clk_rise   = clkin_s2_q & ~clkin_p_q;

    // Wire order stored active-low; ID nibble always reads as released.
    assign load_word = {4'hF,
                        ~button_data[9], ~button_data[8], ~button_data[6], ~button_data[4],
                        ~button_data[3], ~button_data[2], ~button_data[1], ~button_data[0],
                        ~button_data[11], ~button_data[10], ~button_data[7], ~button_data[5]};

    always_ff @(posedge clk) begin
        if (res) begin
            latch_s1_q <= 1'b0;
            latch_s2_q <= 1'b0;
            latch_p_q  <= 1'b0;
            clkin_s1_q <= 1'b1;
            clkin_s2_q <= 1'b1;
            clkin_p_q  <= 1'b1;
        end else begin
            latch_s1_q <= bus.latch;
            latch_s2_q <= latch_s1_q;
            latch_p_q  <= latch_s2_q;
            clkin_s1_q <= bus.clkin;
            clkin_s2_q <= clkin_s1_q;
            clkin_p_q  <= clkin_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            idx_q        <= 4'd0;
            shreg_q      <= 16'hFFFF;
            data_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef JOYPAD_DEVICE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= 11'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
`ifdef JOYPAD_DEVICE_TIMEOUT_EN
        cnt_d        = 11'd0;
`endif

        unique case (state_q)
            StIdle: begin
                data_d = 1'b1;
                idx_d  = 4'd0;
            end
            StLoad: begin
                shreg_d = load_word;
                data_d  = load_word[0];
                idx_d   = 4'd0;
                if (latch_fall) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (clk_rise) begin
                    if (idx_q == 4'd15) begin
                        state_d      = StDone;
                        data_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        data_d = shreg_q[idx_q + 4'd1];
                    end
                end
`ifdef JOYPAD_DEVICE_TIMEOUT_EN
                else if (cnt_q == 11'd1371) begin
                    state_d = StIdle;
                    data_d  = 1'b1;
                    idx_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
`endif
            end
            StDone: begin
                data_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                data_d  = 1'b1;
            end
        endcase

        // Latch dominates every state and any simultaneous clock edge.
        if (latch_sync) begin
            state_d      = StLoad;
            shreg_d      = load_word;
            data_d       = load_word[0];
            idx_d        = 4'd0;
            frame_done_d = 1'b0;
`ifdef JOYPAD_DEVICE_TIMEOUT_EN
            cnt_d        = 11'd0;
`endif
        end
    end

    assign bus.data   = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joypad_device.sv
// Directed self-checking bench for joypad_device; honours JOYPAD_DEVICE_TIMEOUT_EN when defined.
module tb_joypad_device;

    logic        clk = 1'b0;
    logic        res;
    logic [11:0] button_data;
    logic        frame_done;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fd_cnt  = 0;
    int          fd0;
    logic [15:0] w;

    joypad_device_if bus ();

    joypad_device dut (
        .clk         (clk),
        .res         (res),
        .bus         (bus.slave),
        .button_data (button_data),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_pulse();
        bus.clkin = 1'b0;
        tick(4);
        bus.clkin = 1'b1;
        tick(4);
    endtask

    task automatic start_frame(input logic [11:0] btn);
        button_data = btn;
        bus.latch   = 1'b1;
        tick(6);
        bus.latch   = 1'b0;
        tick(6);
    endtask

    task automatic read_frame(output logic [15:0] word);
        word[0] = bus.data;
        for (int i = 1; i < 16; i++) begin
            clk_pulse();
            word[i] = bus.data;
        end
    endtask

    task automatic run_frame(input string tag, input logic [11:0] btn, input logic [15:0] exp);
        logic [15:0] word;
        int          f0;
        start_frame(btn);
        f0 = fd_cnt;
        read_frame(word);
        check({tag, "_word"}, 32'(word), 32'(exp));
        clk_pulse();
        check({tag, "_done_data"}, 32'(bus.data), 32'd0);
        check({tag, "_done_pulse"}, 32'(fd_cnt - f0), 32'd1);
    endtask

    initial begin
        res         = 1'b1;
        bus.latch   = 1'b0;
        bus.clkin   = 1'b1;
        button_data = 12'h000;
        tick(3);
        check("reset_data", 32'(bus.data), 32'd1);
        check("reset_fd", 32'(frame_done), 32'd0);
        res = 1'b0;
        tick(3);
        clk_pulse();
        check("idle_clk_ignored", 32'(bus.data), 32'd1);

        // B only: latched data shows ~B while latch is held
        button_data = 12'h020;
        bus.latch   = 1'b1;
        tick(6);
        check("load_data_b", 32'(bus.data), 32'd0);
        clk_pulse();
        check("load_clk_ignored", 32'(bus.data), 32'd0);
        bus.latch = 1'b0;
        tick(6);
        fd0 = fd_cnt;
        read_frame(w);
        check("b_only_word", 32'(w), 32'hFFFE);
        clk_pulse();
        check("b_only_done_data", 32'(bus.data), 32'd0);
        check("b_only_done_pulse", 32'(fd_cnt - fd0), 32'd1);
        clk_pulse();
        clk_pulse();
        check("done_ignores_clk", 32'(bus.data), 32'd0);
        check("done_no_extra_pulse", 32'(fd_cnt - fd0), 32'd1);

        run_frame("all_pressed", 12'hFFF, 16'hF000);
        run_frame("dpad", 12'h00F, 16'hFF0F);

        // Abort after 5 bits by re-latching
        start_frame(12'h020);
        fd0 = fd_cnt;
        repeat (5) clk_pulse();
        bus.latch = 1'b1;
        tick(6);
        check("abort_load_data", 32'(bus.data), 32'd0);
        check("abort_no_pulse", 32'(fd_cnt - fd0), 32'd0);
        bus.latch = 1'b0;
        tick(4);
        run_frame("after_abort", 12'h630, 16'hF6FA);

        // Buttons change after latch falls: frame keeps "up" pressed, start released
        start_frame(12'h001);
        button_data = 12'h800;
        read_frame(w);
        check("sample_hold_word", 32'(w), 32'hFFEF);
        clk_pulse();

        // Latch rise coincident with clkin rise
        start_frame(12'h02F);
        clk_pulse();
        clk_pulse();
        bus.clkin = 1'b0;
        tick(4);
        bus.latch = 1'b1;
        bus.clkin = 1'b1;
        tick(6);
        check("coincident_load", 32'(bus.data), 32'd0);
        bus.latch = 1'b0;
        tick(6);
        fd0 = fd_cnt;
        read_frame(w);
        check("coincident_word", 32'(w), 32'hFF0E);
        clk_pulse();
        check("coincident_pulse", 32'(fd_cnt - fd0), 32'd1);

        // Reset mid-frame aborts silently and requires a new latch
        start_frame(12'h020);
        fd0 = fd_cnt;
        repeat (4) clk_pulse();
        res = 1'b1;
        tick(2);
        res = 1'b0;
        tick(2);
        check("midreset_data", 32'(bus.data), 32'd1);
        repeat (3) clk_pulse();
        check("midreset_needs_latch", 32'(bus.data), 32'd1);
        check("midreset_no_pulse", 32'(fd_cnt - fd0), 32'd0);

        // Long stall after 3 bits; start pressed so bit 3 reads 0
        start_frame(12'h800);
        fd0 = fd_cnt;
        repeat (3) clk_pulse();
        check("stall_bit3", 32'(bus.data), 32'd0);
        tick(1372);
`ifdef JOYPAD_DEVICE_TIMEOUT_EN
        check("timeout_idle_data", 32'(bus.data), 32'd1);
        repeat (13) clk_pulse();
        check("timeout_stays_idle", 32'(bus.data), 32'd1);
        check("timeout_no_pulse", 32'(fd_cnt - fd0), 32'd0);
`else
        check("stall_still_bit3", 32'(bus.data), 32'd0);
        clk_pulse();
        check("stall_bit4", 32'(bus.data), 32'd1);
        repeat (11) clk_pulse();
        check("stall_bit15", 32'(bus.data), 32'd1);
        check("stall_no_pulse_yet", 32'(fd_cnt - fd0), 32'd0);
        clk_pulse();
        check("stall_done_data", 32'(bus.data), 32'd0);
        check("stall_done_pulse", 32'(fd_cnt - fd0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
